// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter and its helpers.
package reg_write_arbiter_pkg;

    localparam int unsigned REG_COUNT          = 8;
    localparam int unsigned ADDR_WIDTH         = 3;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned GRANT_ID_WIDTH     = 3;

    // Fixed requester slots on the write port.
    typedef enum logic [GRANT_ID_WIDTH-1:0] {
        REQ_ALU   = 3'd0,
        REQ_LOAD  = 3'd1,
        REQ_CSR   = 3'd2,
        REQ_SPARE = 3'd3
    } req_id_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic [31:0] cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any_c && req[IDX_W'(cand)]) begin
                any_c                  = 1'b1;
                idx_c                  = IDX_W'(cand);
                grant_c[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; one-cycle registered command.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = reg_write_arbiter_pkg::DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = reg_write_arbiter_pkg::ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            hold,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [DATA_WIDTH-1:0]           wr_data,
    output logic [GRANT_ID_WIDTH-1:0]       grant_id
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      pick_idx_c;
    logic [PTR_W-1:0]      next_ptr_c;
    logic [NUM_REQ-1:0]    pick_grant_c;
    logic                  pick_any_c;
    logic                  fire_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_data_c;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Grants are suppressed while held or in reset; an in-flight command is unaffected.
    assign fire_c    = pick_any_c & ~hold & ~reset;
    assign req_ready = fire_c ? pick_grant_c : '0;

    assign next_ptr_c = (pick_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + PTR_W'(1);

    // Payload mux for the winning requester.
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_c == PTR_W'(i)) begin
                sel_addr_c = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_c = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            wr_en <= fire_c;
            if (fire_c) begin
                wr_addr  <= sel_addr_c;
                wr_data  <= sel_data_c;
                grant_id <= GRANT_ID_WIDTH'(pick_idx_c);
                rr_ptr   <= next_ptr_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios followed by random traffic.
module tb_reg_write_arbiter;

    localparam int NR = 4;
    localparam int AW = 3;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              hold = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [2:0]        grant_id;

    reg_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NR-1:0] ready;
    } rdy_t;

    typedef struct {
        int          cyc;
        logic        en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]  id;
    } cmd_t;

    rdy_t ready_q[$];
    cmd_t cmd_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];

    // Reference state: priority pointer plus the last written command.
    int            m_ptr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [2:0]    m_id = '0;

    task automatic step(input logic rst, input logic hld, input logic [NR-1:0] v);
        int   g;
        rdy_t r;
        cmd_t c;
        @(posedge clk);
        #1;
        cyc++;
        reset     = rst;
        hold      = hld;
        req_valid = v;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
        g = -1;
        if (!rst && !hld) begin
            for (int k = 0; k < NR; k++) begin
                if (v[(m_ptr + k) % NR]) begin
                    g = (m_ptr + k) % NR;
                    break;
                end
            end
        end
        r.cyc   = cyc;
        r.ready = '0;
        if (g >= 0) r.ready[g] = 1'b1;
        ready_q.push_back(r);
        if (rst) begin
            m_ptr = 0; m_addr = '0; m_data = '0; m_id = '0;
            c.en = 1'b0;
        end else if (g >= 0) begin
            m_addr = a[g]; m_data = d[g]; m_id = 3'(g);
            m_ptr  = (g + 1) % NR;
            c.en   = 1'b1;
        end else begin
            c.en = 1'b0;
        end
        c.cyc  = cyc;
        c.addr = m_addr;
        c.data = m_data;
        c.id   = m_id;
        cmd_q.push_back(c);
    endtask

    // Monitor: grant checked in its own cycle, command checked one cycle later.
    initial begin
        rdy_t r;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (ready_q.size() > 0 && ready_q[0].cyc == cyc) begin
                r = ready_q.pop_front();
                checks++;
                if (req_ready !== r.ready) begin
                    errors++;
                    $display("FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, r.ready);
                end
            end
            if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc - 1) begin
                c = cmd_q.pop_front();
                checks++;
                if (wr_en !== c.en || wr_addr !== c.addr || wr_data !== c.data || grant_id !== c.id) begin
                    errors++;
                    $display("FAIL wr_cmd cyc=%0d got en=%b addr=%0d data=%h id=%0d want en=%b addr=%0d data=%h id=%0d",
                             cyc, wr_en, wr_addr, wr_data, grant_id, c.en, c.addr, c.data, c.id);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        // Reset then idle.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        repeat (3) step(1'b0, 1'b0, 4'b0000);
        // Single requester.
        a[1] = 3'd5; d[1] = 32'hDEADBEEF;
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        // All four requesting from reset.
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < NR; i++) begin
            a[i] = 3'(i + 4);
            d[i] = 32'hA000_0000 + 32'(i);
        end
        repeat (6) step(1'b0, 1'b0, 4'b1111);
        // Hold mid-stream.
        repeat (3) step(1'b0, 1'b1, 4'b1111);
        repeat (3) step(1'b0, 1'b0, 4'b1111);
        // Same-address conflict from rr_ptr=0.
        step(1'b1, 1'b0, 4'b0000);
        a[0] = 3'd3; d[0] = 32'h11;
        a[2] = 3'd3; d[2] = 32'h22;
        step(1'b0, 1'b0, 4'b0101);
        step(1'b0, 1'b0, 4'b0100);
        step(1'b0, 1'b0, 4'b0000);
        // Reset right after a grant to requester 2.
        step(1'b1, 1'b0, 4'b0000);
        repeat (3) step(1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        repeat (2) step(1'b0, 1'b0, 4'b1111);
        // Writes to register 0 pass through.
        a[3] = 3'd0; d[3] = 32'h0BAD_F00D;
        step(1'b0, 1'b0, 4'b1000);
        step(1'b0, 1'b0, 4'b0000);
        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) begin
                a[i] = 3'($urandom_range(0, 7));
                d[i] = $urandom;
            end
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), 4'($urandom));
        end
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        #1;
        checks++;
        if (ready_q.size() != 0 || cmd_q.size() > 1) begin
            errors++;
            $display("FAIL drain got ready_q=%0d cmd_q=%0d want ready_q=0 cmd_q<=1", ready_q.size(), cmd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
